// File: rtl/regwr_arbiter_if.sv
// regwr_arbiter_if
//   Requester-side bus of the register-bank write arbiter: packed request
//   vectors going in, the registered bank write port and acknowledge coming out.
//   master: requester cluster / bench.  slave: regwr_arbiter.
interface regwr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    i_req;
  logic [NREQ*AW-1:0] i_addr;
  logic [NREQ*DW-1:0] i_data;
  logic               i_hold;
  logic [NREQ-1:0]    o_ack;
  logic               o_we;
  logic [AW-1:0]      o_waddr;
  logic [DW-1:0]      o_wdata;
  logic [GW-1:0]      o_gnt_id;

  modport master (
    output i_req, i_addr, i_data, i_hold,
    input  o_ack, o_we, o_waddr, o_wdata, o_gnt_id
  );

  modport slave (
    input  i_req, i_addr, i_data, i_hold,
    output o_ack, o_we, o_waddr, o_wdata, o_gnt_id
  );
endinterface

// File: rtl/regwr_arbiter.sv
// regwr_arbiter
//   Shares one register-bank write port among NREQ requesters. Each cycle at
//   most one eligible request wins; its address/data are registered and a
//   single-cycle write strobe plus one-hot acknowledge are issued.
//   A requester whose ack is currently high is masked for that cycle so it
//   can drop or change its request before being considered again.
//
//   Build option REGWR_ARB_FIXED_PRI_EN:
//     defined   -> fixed priority, lowest index wins, no rotating pointer
//     undefined -> round-robin starting at the rotating pointer (default)
module regwr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  regwr_arbiter_if.slave  bus
);

  localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW1 = GW + 1;
  // NREQ at the width of the wrapped scan sum, so the modulo compare is width-matched
  localparam logic [GW:0] NREQ_W = GW1'(NREQ);

  // Registered outputs
  logic [NREQ-1:0] r_ack;
  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [DW-1:0]   r_wdata;
  logic [GW-1:0]   r_gnt_id;

  // Arbitration wires
  logic [NREQ-1:0] w_elig;
  logic [GW-1:0]   w_start;
  logic            w_found;
  logic [GW-1:0]   w_win;
  logic            w_grant;
  logic [NREQ-1:0] w_onehot;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;

  // A requester acknowledged this cycle gets one cycle to retire its request
  assign w_elig  = bus.i_req & ~r_ack;
  assign w_grant = w_found & ~bus.i_hold;

`ifdef REGWR_ARB_FIXED_PRI_EN
  // Fixed priority: the scan always begins at requester 0
  assign w_start = {GW{1'b0}};
`else
  localparam logic [GW-1:0] LAST = GW'(NREQ - 1);

  logic [GW-1:0] r_ptr;
  logic [GW-1:0] w_ptr_nxt;

  assign w_start = r_ptr;

  // Next pointer is the slot just after the winner, wrapping past the last requester
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_win == LAST) begin
      w_ptr_nxt = {GW{1'b0}};
    end else begin
      w_ptr_nxt = w_win + {{(GW-1){1'b0}}, 1'b1};
    end
  end

  // Round-robin pointer advances only when a grant is actually issued
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= {GW{1'b0}};
    end else if (w_grant) begin
      r_ptr <= w_ptr_nxt;
    end else begin
      r_ptr <= r_ptr;
    end
  end
`endif

  // Circular scan of the eligible set from w_start; first set bit wins
  always_comb begin
    logic [GW:0]   w_sum;
    logic [GW-1:0] w_idx;
    w_found = 1'b0;
    w_win   = {GW{1'b0}};
    w_sum   = {GW1{1'b0}};
    w_idx   = {GW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, w_start} + i[GW:0];
      if (w_sum >= NREQ_W) begin
        w_sum = w_sum - NREQ_W;
      end else begin
        w_sum = w_sum;
      end
      w_idx = w_sum[GW-1:0];
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end else begin
        w_found = w_found;
        w_win   = w_win;
      end
    end
  end

  // One-hot decode of the winner and AND-OR selection of its address and data
  always_comb begin
    logic w_sel;
    w_onehot = {NREQ{1'b0}};
    w_addr   = {AW{1'b0}};
    w_data   = {DW{1'b0}};
    w_sel    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_sel       = (w_win == k[GW-1:0]);
      w_onehot[k] = w_sel;
      w_addr      = w_addr | (bus.i_addr[k*AW +: AW] & {AW{w_sel}});
      w_data      = w_data | (bus.i_data[k*DW +: DW] & {DW{w_sel}});
    end
  end

  // Output stage: load winner on grant, otherwise drop strobes and keep payload
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ack    <= {NREQ{1'b0}};
      r_we     <= 1'b0;
      r_waddr  <= {AW{1'b0}};
      r_wdata  <= {DW{1'b0}};
      r_gnt_id <= {GW{1'b0}};
    end else if (w_grant) begin
      r_ack    <= w_onehot;
      r_we     <= 1'b1;
      r_waddr  <= w_addr;
      r_wdata  <= w_data;
      r_gnt_id <= w_win;
    end else begin
      r_ack    <= {NREQ{1'b0}};
      r_we     <= 1'b0;
      r_waddr  <= r_waddr;
      r_wdata  <= r_wdata;
      r_gnt_id <= r_gnt_id;
    end
  end

  assign bus.o_ack    = r_ack;
  assign bus.o_we     = r_we;
  assign bus.o_waddr  = r_waddr;
  assign bus.o_wdata  = r_wdata;
  assign bus.o_gnt_id = r_gnt_id;

endmodule

// File: tb/tb_regwr_arbiter.sv
// tb_regwr_arbiter
//   Directed stimulus pushes the hand-derived expected output of every cycle
//   into a scoreboard queue; an independent monitor on the falling edge pops
//   and compares whenever an entry is due, and insists on o_we=0 otherwise.
module tb_regwr_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;
`ifdef REGWR_ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct {
    int              cyc;
    logic            we;
    logic [NREQ-1:0] ack;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [1:0]      gid;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   gcount [NREQ];
  exp_t q [$];

  logic [AW-1:0] tb_addr [NREQ];
  logic [DW-1:0] tb_data [NREQ];
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;
  logic [1:0]    last_gid  = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regwr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  regwr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_payload();
    for (int k = 0; k < NREQ; k++) begin
      bus.i_addr[k*AW +: AW] = tb_addr[k];
      bus.i_data[k*DW +: DW] = tb_data[k];
    end
  endtask

  task automatic push_grant(input int at, input int w);
    exp_t e;
    logic [NREQ-1:0] one;
    one    = {{(NREQ-1){1'b0}}, 1'b1};
    e.cyc  = at;
    e.we   = 1'b1;
    e.ack  = one << w;
    e.addr = tb_addr[w];
    e.data = tb_data[w];
    e.gid  = w[1:0];
    last_addr = e.addr;
    last_data = e.data;
    last_gid  = e.gid;
    q.push_back(e);
  endtask

  task automatic push_idle(input int at);
    exp_t e;
    e.cyc  = at;
    e.we   = 1'b0;
    e.ack  = '0;
    e.addr = last_addr;
    e.data = last_data;
    e.gid  = last_gid;
    q.push_back(e);
  endtask

  // One cycle of stimulus; w = expected winner, or -1 for no grant
  task automatic step(input logic [NREQ-1:0] req, input logic hold, input int w);
    @(negedge clk);
    bus.i_req  = req;
    bus.i_hold = hold;
    drive_payload();
    if (w < 0) push_idle(cyc + 1);
    else       push_grant(cyc + 1, w);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"},   32'(bus.o_we),     32'd0);
    chk({tag, "_ack"},  32'(bus.o_ack),    32'd0);
    chk({tag, "_addr"}, 32'(bus.o_waddr),  32'd0);
    chk({tag, "_data"}, 32'(bus.o_wdata),  32'd0);
    chk({tag, "_gid"},  32'(bus.o_gnt_id), 32'd0);
  endtask

  // Monitor: compare the entry due this cycle, otherwise require no write strobe
  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missed_entry: expectation for cycle %0d never checked, now %0d", e.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("we",    32'(bus.o_we),     32'(e.we));
      chk("ack",   32'(bus.o_ack),    32'(e.ack));
      chk("waddr", 32'(bus.o_waddr),  32'(e.addr));
      chk("wdata", 32'(bus.o_wdata),  32'(e.data));
      chk("gid",   32'(bus.o_gnt_id), 32'(e.gid));
    end else begin
      chk("unexpected_we", 32'(bus.o_we), 32'd0);
    end
    if (bus.o_we) gcount[bus.o_gnt_id]++;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    for (int k = 0; k < NREQ; k++) begin
      tb_addr[k] = AW'(10 + k);
      tb_data[k] = 32'hA000_0000 + 32'(k);
      gcount[k]  = 0;
    end
    rst        = 1'b1;
    bus.i_req  = 4'b0001;
    bus.i_hold = 1'b0;
    drive_payload();
    repeat (2) @(negedge clk);
    check_zero("rst_init");

    // Release reset with requester 0 already asking
    rst = 1'b0;
    push_grant(cyc + 1, 0);
    step(4'b0001, 1'b0, -1);            // masked during its own ack
    step(4'b0001, 1'b0, 0);             // re-granted

    // Mid-cycle reset while a grant is on the bus clears everything at once
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("rst_async");
    last_addr = '0;
    last_data = '0;
    last_gid  = '0;
    @(negedge clk);
    rst = 1'b0;
    push_grant(cyc + 1, 0);             // first write one cycle after release
    step(4'b0000, 1'b0, -1);
    step(4'b0000, 1'b0, -1);            // ptr now 1

    // Single request from requester 2
    tb_addr[2] = 5'd7;
    tb_data[2] = 32'hDEAD_BEEF;
    step(4'b0100, 1'b0, 2);
    step(4'b0000, 1'b0, -1);            // ptr now 3

    // Hold for three cycles, then arbitration resumes at the preserved pointer
    step(4'b1001, 1'b1, -1);
    step(4'b1001, 1'b1, -1);
    step(4'b1001, 1'b1, -1);
    step(4'b1001, 1'b0, FIXED ? 0 : 3);
    step(4'b1001, 1'b0, FIXED ? 3 : 0);
    step(4'b0000, 1'b0, -1);            // ptr now 1

    // Lone requester held high: grant every other cycle
    for (int i = 0; i < 6; i++) step(4'b0010, 1'b0, (i % 2 == 0) ? 1 : -1);
    step(4'b0000, 1'b0, -1);            // ptr now 2

    // Requesters 0 and 2 held high: strict alternation
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step(4'b0101, 1'b0, FIXED ? 0 : 2);
      else            step(4'b0101, 1'b0, FIXED ? 2 : 0);
    end
    step(4'b0000, 1'b0, -1);            // ptr now 1

    // All four held high for eight grants
    @(posedge clk);
    #1;
    for (int k = 0; k < NREQ; k++) gcount[k] = 0;
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, FIXED ? (i % 2) : ((1 + i) % 4));
    step(4'b0000, 1'b0, -1);

    @(negedge clk);
    @(posedge clk);
    #1;
    for (int k = 0; k < NREQ; k++) begin
      chk($sformatf("fair_count%0d", k), 32'(gcount[k]), FIXED ? ((k < 2) ? 32'd4 : 32'd0) : 32'd2);
    end
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
